dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_arbiter_if.sv | 58 +++++
 rtl/dmem_arb_pick.sv | 50 +++++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM states, port ids and default parameters for dmem_arbiter
package dmem_pkg;

  // One access in flight at a time, walked through these four states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

  // Requester identities as seen by the picker and the response steering.
  localparam logic PORT_PIPE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  // Default build parameters.
  localparam int DEF_ADDR_W       = 64;
  localparam int DEF_DATA_W       = 64;
  localparam int DEF_RD_LATENCY   = 1;
  localparam int DEF_STARVE_LIMIT = 4;

  // Counter widths: read latency is at most 7, starvation limit at most 15.
  localparam int WAIT_CNT_W   = 3;
  localparam int STARVE_CNT_W = 4;

  // Value loaded into the WAIT down-counter when leaving ISSUE on a load.
  function automatic logic [WAIT_CNT_W-1:0] wait_init(input int rd_latency);
    return WAIT_CNT_W'(rd_latency - 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request, response and memory signal bundle for dmem_arbiter
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Port 0: pipeline MEM stage.
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  // Port 1: loader / debug DMA.
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  // Data memory side.
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter view.
  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata,
    output busy
  );

  // Requesters plus memory view.
  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - two-way port picker; DMEM_ARB_STARVE_EN adds the port-1 starvation counter
module dmem_arb_pick
  import dmem_pkg::*;
`ifdef DMEM_ARB_STARVE_EN
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
)
`endif
(
`ifdef DMEM_ARB_STARVE_EN
  input  logic clk,
  input  logic reset,
  input  logic grant_take,
`endif
  input  logic req0_valid,
  input  logic req1_valid,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0_valid | req1_valid;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    force_dma;

  // Port 1 has lost LIMIT times in a row: it takes the next arbitration.
  assign force_dma = (starve_cnt >= LIMIT) && req1_valid;
  assign grant_id  = (req1_valid && (!req0_valid || force_dma)) ? PORT_DMA : PORT_PIPE;

  // Count port-0 wins taken while port 1 waits; any port-1 win clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_take) begin
      if (grant_id == PORT_DMA) begin
        starve_cnt <= '0;
      end else if (req1_valid && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  // Strict priority: port 1 only wins when port 0 is not asking.
  assign grant_id = (req1_valid && !req0_valid) ? PORT_DMA : PORT_PIPE;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, one access outstanding; DMEM_ARB_STARVE_EN enables port-1 fairness
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LATENCY   = DEF_RD_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_rd_latency
      $error("dmem_arbiter: RD_LATENCY must be within 1..7");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > (1 << STARVE_CNT_W) - 1) begin : g_bad_starve_limit
      $error("dmem_arbiter: STARVE_LIMIT must be within 1..15");
    end
  endgenerate

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = wait_init(RD_LATENCY);

  dmem_state_t             state;
  logic                    port_q;
  logic                    write_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt;

  logic                    mem_write_q;
  logic                    mem_read_q;
  logic                    rsp0_valid_q;
  logic                    rsp1_valid_q;
  logic [DATA_W-1:0]       rsp0_rdata_q;
  logic [DATA_W-1:0]       rsp1_rdata_q;

  logic                    grant_valid;
  logic                    grant_id;
  logic                    grant_take;
  logic                    sel_write;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;
  logic                    finish;
  logic [DATA_W-1:0]       rsp_data;

  dmem_arb_pick
`ifdef DMEM_ARB_STARVE_EN
    #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
  u_pick (
`ifdef DMEM_ARB_STARVE_EN
    .clk         (clk),
    .reset       (reset),
    .grant_take  (grant_take),
`endif
    .req0_valid  (bus.req0_valid),
    .req1_valid  (bus.req1_valid),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // A grant only happens in IDLE; ready is the combinational echo of it.
  assign grant_take     = (state == IDLE) && grant_valid && !reset;
  assign bus.req0_ready = grant_take && (grant_id == PORT_PIPE);
  assign bus.req1_ready = grant_take && (grant_id == PORT_DMA);

  assign sel_write = (grant_id == PORT_DMA) ? bus.req1_write : bus.req0_write;
  assign sel_addr  = (grant_id == PORT_DMA) ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = (grant_id == PORT_DMA) ? bus.req1_wdata : bus.req0_wdata;

  // Stores finish straight out of ISSUE with zero data; loads finish when the
  // WAIT counter expires, which is the cycle mem_rdata is valid.
  assign finish   = ((state == ISSUE) && write_q) || ((state == WAIT) && (wait_cnt == '0));
  assign rsp_data = (state == WAIT) ? bus.mem_rdata : '0;

  // Access sequencing: latch on grant, strobe memory in ISSUE, wait, then respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      port_q       <= PORT_PIPE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_cnt     <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_take) begin
            port_q      <= grant_id;
            write_q     <= sel_write;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            mem_write_q <= sel_write;
            mem_read_q  <= !sel_write;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_INIT;
          state    <= write_q ? RESP : WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (finish) begin
        if (port_q == PORT_PIPE) begin
          rsp0_valid_q <= 1'b1;
          rsp0_rdata_q <= rsp_data;
        end else begin
          rsp1_valid_q <= 1'b1;
          rsp1_rdata_q <= rsp_data;
        end
      end
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter (RD_LATENCY 1 and 3 instances)
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  function automatic logic [63:0] pat(input logic [7:0] a);
    return 64'h5EED_0000_0000_0000 | ({56'd0, a} << 32) | {56'd0, ~a};
  endfunction

  // Memory behind dut_a: one-cycle read latency.
  logic [63:0] mem_a [256];
  logic [63:0] rd_a;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= pat(8'(i));
    end else if (bus_a.mem_write) begin
      mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    end
    rd_a <= bus_a.mem_read ? mem_a[bus_a.mem_addr[7:0]] : 64'd0;
  end
  assign bus_a.mem_rdata = rd_a;

  // Memory behind dut_b: three-cycle read latency.
  logic [63:0] mem_b [256];
  logic [63:0] rd_b [3];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= pat(8'(i));
    end else if (bus_b.mem_write) begin
      mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
    end
    rd_b[0] <= bus_b.mem_read ? mem_b[bus_b.mem_addr[7:0]] : 64'd0;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign bus_b.mem_rdata = rd_b[2];

  typedef struct {
    logic        port;
    logic [63:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] shadow [256];
  bit          exp_order [10];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next response on dut_a and compare it against the scoreboard head.
  task automatic wait_rsp_a(input int t0);
    exp_t        e;
    bit          got;
    logic        port_seen;
    logic [63:0] data_seen;
    got = 0;
    port_seen = 1'b0;
    data_seen = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      chk_b("mem_strobe_exclusive", bus_a.mem_write & bus_a.mem_read, 1'b0);
      if (bus_a.rsp0_valid || bus_a.rsp1_valid) begin
        got = 1;
        chk_b("rsp_exclusive", bus_a.rsp0_valid & bus_a.rsp1_valid, 1'b0);
        port_seen = bus_a.rsp1_valid;
        data_seen = bus_a.rsp1_valid ? bus_a.rsp1_rdata : bus_a.rsp0_rdata;
      end
    end
    chk_b("rsp_seen", got, 1'b1);
    if (got && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_b("rsp_port", port_seen, e.port);
      chk_w("rsp_rdata", data_seen, e.rdata);
      chk_w("rsp_latency", 64'(cyc - t0), 64'(e.lat));
      tick();
      chk_b("idle_after_rsp", bus_a.busy, 1'b0);
    end
  endtask

  // One complete access on dut_a from a single port.
  task automatic access_a(input logic port, input logic wr, input logic [7:0] addr, input logic [63:0] wdata);
    exp_t e;
    bit   got;
    int   t0;
    if (port == PORT_PIPE) begin
      bus_a.req0_valid = 1'b1; bus_a.req0_write = wr;
      bus_a.req0_addr = {56'd0, addr}; bus_a.req0_wdata = wdata;
    end else begin
      bus_a.req1_valid = 1'b1; bus_a.req1_write = wr;
      bus_a.req1_addr = {56'd0, addr}; bus_a.req1_wdata = wdata;
    end
    #1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((port == PORT_PIPE) ? bus_a.req0_ready : bus_a.req1_ready) got = 1;
      else tick();
    end
    chk_b("grant_seen", got, 1'b1);
    t0 = cyc;
    e.port = port;
    e.lat = wr ? 2 : 3;
    e.rdata = wr ? 64'd0 : shadow[addr];
    if (wr) shadow[addr] = wdata;
    sb_q.push_back(e);
    tick();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    chk_b("issue_write", bus_a.mem_write, wr);
    chk_b("issue_read", bus_a.mem_read, !wr);
    chk_w("issue_addr", bus_a.mem_addr, {56'd0, addr});
    if (wr) chk_w("issue_wdata", bus_a.mem_wdata, wdata);
    wait_rsp_a(t0);
  endtask

  initial begin
    exp_t        e;
    bit          got;
    bit          seen;
    bit          busy_ok;
    int          t0;
    int          reads;
    logic        port_seen;
    logic [63:0] data_seen;

    for (int i = 0; i < 256; i++) shadow[i] = pat(8'(i));
`ifdef DMEM_ARB_STARVE_EN
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    bus_a.req0_valid = 1'b0; bus_a.req0_write = 1'b0; bus_a.req0_addr = '0; bus_a.req0_wdata = '0;
    bus_a.req1_valid = 1'b0; bus_a.req1_write = 1'b0; bus_a.req1_addr = '0; bus_a.req1_wdata = '0;
    bus_b.req0_valid = 1'b0; bus_b.req0_write = 1'b0; bus_b.req0_addr = '0; bus_b.req0_wdata = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_write = 1'b0; bus_b.req1_addr = '0; bus_b.req1_wdata = '0;

    // Reset state, with a request pending that must not be granted.
    tick();
    tick();
    bus_a.req0_valid = 1'b1;
    #1;
    chk_b("rst_req0_ready", bus_a.req0_ready, 1'b0);
    chk_b("rst_busy", bus_a.busy, 1'b0);
    chk_b("rst_mem_write", bus_a.mem_write, 1'b0);
    chk_b("rst_mem_read", bus_a.mem_read, 1'b0);
    chk_w("rst_mem_addr", bus_a.mem_addr, 64'd0);
    chk_b("rst_rsp0_valid", bus_a.rsp0_valid, 1'b0);
    chk_b("rst_rsp1_valid", bus_a.rsp1_valid, 1'b0);
    chk_b("rst_b_busy", bus_b.busy, 1'b0);
    bus_a.req0_valid = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Port-0 store then port-1 load of the same word, then a few more mixes.
    access_a(PORT_PIPE, 1'b1, 8'h10, 64'hDEAD);
    access_a(PORT_DMA,  1'b0, 8'h10, 64'd0);
    access_a(PORT_DMA,  1'b1, 8'h20, 64'hCAFE_F00D_1234_5678);
    access_a(PORT_PIPE, 1'b0, 8'h20, 64'd0);
    access_a(PORT_PIPE, 1'b0, 8'h33, 64'd0);

    // Both valid together: port 0 first, port 1 in the following IDLE.
    bus_a.req0_valid = 1'b1; bus_a.req0_write = 1'b1; bus_a.req0_addr = 64'h40; bus_a.req0_wdata = 64'h4040;
    bus_a.req1_valid = 1'b1; bus_a.req1_write = 1'b0; bus_a.req1_addr = 64'h10; bus_a.req1_wdata = '0;
    #1;
    chk_b("both_ready0", bus_a.req0_ready, 1'b1);
    chk_b("both_ready1", bus_a.req1_ready, 1'b0);
    e.port = PORT_PIPE; e.rdata = 64'd0; e.lat = 2;
    shadow[8'h40] = 64'h4040;
    sb_q.push_back(e);
    t0 = cyc;
    tick();
    bus_a.req0_valid = 1'b0;
    chk_b("both_no_ready_busy", bus_a.req1_ready, 1'b0);
    wait_rsp_a(t0);
    chk_b("second_ready1", bus_a.req1_ready, 1'b1);
    e.port = PORT_DMA; e.rdata = shadow[8'h10]; e.lat = 3;
    sb_q.push_back(e);
    t0 = cyc;
    tick();
    bus_a.req1_valid = 1'b0;
    wait_rsp_a(t0);

    // Both continuously valid: grant order depends on the fairness build.
    bus_a.req0_valid = 1'b1; bus_a.req0_write = 1'b0; bus_a.req0_addr = 64'h50;
    bus_a.req1_valid = 1'b1; bus_a.req1_write = 1'b0; bus_a.req1_addr = 64'h58;
    for (int g = 0; g < 10; g++) begin
      got = 0;
      for (int i = 0; i < 12 && !got; i++) begin
        #1;
        if (bus_a.req0_ready || bus_a.req1_ready) got = 1;
        else tick();
      end
      chk_b("order_grant_seen", got, 1'b1);
      chk_b($sformatf("grant_order_%0d", g), bus_a.req1_ready, exp_order[g]);
      tick();
    end
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    for (int i = 0; i < 20 && bus_a.busy; i++) tick();
    chk_b("drain_idle", bus_a.busy, 1'b0);

    // Reset landing in WAIT of a load: everything clears, no response.
    bus_a.req0_valid = 1'b1; bus_a.req0_write = 1'b0; bus_a.req0_addr = 64'h10;
    #1;
    chk_b("rstwait_ready", bus_a.req0_ready, 1'b1);
    tick();
    bus_a.req0_valid = 1'b0;
    chk_b("rstwait_read", bus_a.mem_read, 1'b1);
    tick();
    chk_b("rstwait_busy_pre", bus_a.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk_b("rstwait_busy", bus_a.busy, 1'b0);
    chk_b("rstwait_mem_read", bus_a.mem_read, 1'b0);
    chk_b("rstwait_mem_write", bus_a.mem_write, 1'b0);
    chk_w("rstwait_mem_addr", bus_a.mem_addr, 64'd0);
    chk_b("rstwait_rsp0", bus_a.rsp0_valid, 1'b0);
    chk_b("rstwait_rsp1", bus_a.rsp1_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_a.rsp0_valid || bus_a.rsp1_valid || bus_a.busy) seen = 1;
    end
    chk_b("rstwait_no_rsp", seen, 1'b0);
    access_a(PORT_DMA,  1'b1, 8'h60, 64'h0123_4567_89AB_CDEF);
    access_a(PORT_PIPE, 1'b0, 8'h60, 64'd0);

    // RD_LATENCY=3 load on dut_b.
    bus_b.req0_valid = 1'b1; bus_b.req0_write = 1'b0; bus_b.req0_addr = 64'h30;
    #1;
    chk_b("b_ready", bus_b.req0_ready, 1'b1);
    e.port = PORT_PIPE; e.rdata = pat(8'h30); e.lat = 5;
    sb_q.push_back(e);
    t0 = cyc;
    tick();
    bus_b.req0_valid = 1'b0;
    reads = 0;
    busy_ok = 1;
    got = 0;
    port_seen = 1'b0;
    data_seen = '0;
    for (int i = 0; i < 15 && !got; i++) begin
      if (bus_b.mem_read) reads++;
      if (!bus_b.busy) busy_ok = 0;
      if (bus_b.rsp0_valid || bus_b.rsp1_valid) begin
        got = 1;
        port_seen = bus_b.rsp1_valid;
        data_seen = bus_b.rsp1_valid ? bus_b.rsp1_rdata : bus_b.rsp0_rdata;
      end else begin
        tick();
      end
    end
    chk_b("b_rsp_seen", got, 1'b1);
    if (got && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_b("b_rsp_port", port_seen, e.port);
      chk_w("b_rsp_rdata", data_seen, e.rdata);
      chk_w("b_rsp_latency", 64'(cyc - t0), 64'(e.lat));
    end
    chk_w("b_mem_read_cycles", 64'(reads), 64'd1);
    chk_b("b_busy_throughout", busy_ok, 1'b1);
    tick();
    chk_b("b_idle_after", bus_b.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

endmodule
